hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting between IF/ID, ID/EX and the
//  data-memory port. Detects load-use hazards (gated by per-source valid bits, x0-exempt), inserts a
//  configurable number of bubble cycles, flushes on taken branch, freezes on data-memory busy, and counts stalls.
//  Stall/flush sequencing is registered (FSM); hazard detection is combinational off the current pipeline regs.
// PARAMETERS
//  REG_AW       5   register-address width (rd/rs1/rs2 fields)
//  LOAD_BUBBLES 1   bubble cycles per load-use hazard (1 = MEM->EX forwarding present, 2 = WB->EX only); range 1..7
//  X0_EXEMPT    1   1: rd==0 never causes a hazard
//  CNT_W        16  width of stall-cycle counter
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  id_ex_mem_rd   in   1       ID/EX instruction is a load
//  id_ex_rd       in   REG_AW  ID/EX destination register
//  if_id_rs1      in   REG_AW  IF/ID source register 1
//  if_id_rs2      in   REG_AW  IF/ID source register 2
//  if_id_rs1_vld  in   1       IF/ID instruction actually reads rs1
//  if_id_rs2_vld  in   1       IF/ID instruction actually reads rs2
//  branch_taken   in   1       EX-stage branch/jump redirect this cycle
//  dmem_busy      in   1       data memory not ready; whole pipe must freeze
//  stall_cnt_clr  in   1       synchronous clear of stall_cnt
//  pc_en          out  1       1 = PC updates
//  if_id_en       out  1       1 = IF/ID register loads
//  id_ex_ctrl_sel out  1       1 = pass decoded controls into ID/EX, 0 = inject bubble (all controls zero)
//  if_id_flush    out  1       1 = IF/ID loads a NOP
//  pipe_hold      out  1       1 = ID/EX, EX/MEM, MEM/WB hold their contents
//  stall_active   out  1       1 = a load-use bubble is being inserted this cycle
//  stall_cnt      out  CNT_W   saturating count of load-use bubble cycles
// BEHAVIOUR
//  hz = id_ex_mem_rd & ((rs1_vld & rs1==rd) | (rs2_vld & rs2==rd)) & ~(X0_EXEMPT & rd==0).
//  FSM states: RUN, LDSTALL (with remaining-bubble counter bcnt, 3 bits).
//  Output priority each cycle (highest first):
//   1 dmem_busy: pc_en=0, if_id_en=0, pipe_hold=1, id_ex_ctrl_sel=1, if_id_flush=0, stall_active=0;
//     state, bcnt, stall_cnt hold; branch_taken and hz ignored (re-presented after freeze).
//   2 branch_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_ctrl_sel=0, pipe_hold=0, stall_active=0;
//     next state RUN, bcnt=0 (pending bubbles dropped, wrong-path instruction discarded).
//   3 RUN & hz, or LDSTALL: pc_en=0, if_id_en=0, id_ex_ctrl_sel=0, pipe_hold=0, if_id_flush=0,
//     stall_active=1; stall_cnt += 1 (saturates at all-ones).
//     RUN & hz: if LOAD_BUBBLES==1 stay RUN, else -> LDSTALL with bcnt=LOAD_BUBBLES-1.
//     LDSTALL: bcnt-=1; when bcnt==1 at this edge -> RUN, bcnt=0.
//   4 otherwise: pc_en=1, if_id_en=1, id_ex_ctrl_sel=1, pipe_hold=0, if_id_flush=0, stall_active=0.
//  Hazard asserts in the same cycle it appears (Mealy, zero latency); first bubble lands in ID/EX next edge.
//  LOAD_BUBBLES=1 behaves identically to a pure combinational load-use detector with rs-valid/x0 gating.
//  stall_cnt_clr clears stall_cnt; if it coincides with an increment, result is 0. Clear ignored only by reset.
//  Reset (rst_n=0, async): state=RUN, bcnt=0, stall_cnt=0; while asserted pc_en=0, if_id_en=0,
//  id_ex_ctrl_sel=0, if_id_flush=0, pipe_hold=0, stall_active=0. Reset mid-LDSTALL abandons remaining bubbles.
//  First cycle after deassert with no hazard: pc_en=1, if_id_en=1, id_ex_ctrl_sel=1.
// TESTING
//  1 LOAD_BUBBLES=1: id_ex_mem_rd=1, rd=5, rs1=5 vld -> exactly 1 cycle pc_en=if_id_en=id_ex_ctrl_sel=0; stall_cnt=1.
//  2 LOAD_BUBBLES=2: same hazard then id_ex_mem_rd=0 -> 2 consecutive stall cycles, stall_cnt=2, back to RUN.
//  3 rd=0 load, rs1=0 vld -> no stall (X0_EXEMPT=1); rd=7, rs2=7 with rs2_vld=0 -> no stall.
//  4 LOAD_BUBBLES=3, branch_taken on 2nd bubble -> if_id_flush=1, id_ex_ctrl_sel=0, pc_en=1; next cycle normal.
//  5 dmem_busy=1 for 4 cycles during LDSTALL -> pipe_hold=1, pc_en=0, stall_cnt frozen; bubbles resume after.
//  6 rst_n pulsed low mid-LDSTALL -> outputs at reset values immediately; after release stall_cnt=0, no bubbles.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch / memory-busy hazard controller for the 5-stage RISC-V pipeline.
// Hazard detection is combinational; multi-bubble sequencing and stall counting are registered.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned X0_EXEMPT    = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mem_rd,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_rs1_vld,
  input  logic              if_id_rs2_vld,
  input  logic              branch_taken,
  input  logic              dmem_busy,
  input  logic              stall_cnt_clr,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_ctrl_sel,
  output logic              if_id_flush,
  output logic              pipe_hold,
  output logic              stall_active,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned BCNT_W = 3;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_LDSTALL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic                rs1_hit_c, rs2_hit_c, x0_block_c, hz_c;
  logic                cnt_inc_c;
  logic                pc_en_c, if_id_en_c, id_ex_ctrl_sel_c;
  logic                if_id_flush_c, pipe_hold_c, stall_active_c;

  // Load-use detection against the instruction currently in IF/ID
  always_comb begin
    rs1_hit_c  = if_id_rs1_vld && (if_id_rs1 == id_ex_rd);
    rs2_hit_c  = if_id_rs2_vld && (if_id_rs2 == id_ex_rd);
    x0_block_c = (X0_EXEMPT != 0) && (id_ex_rd == '0);
    hz_c       = id_ex_mem_rd && (rs1_hit_c || rs2_hit_c) && !x0_block_c;
  end

  // Next-state and pipeline-control decode, highest priority first
  always_comb begin
    state_d          = state_q;
    bcnt_d           = bcnt_q;
    cnt_inc_c        = 1'b0;
    pc_en_c          = 1'b1;
    if_id_en_c       = 1'b1;
    id_ex_ctrl_sel_c = 1'b1;
    if_id_flush_c    = 1'b0;
    pipe_hold_c      = 1'b0;
    stall_active_c   = 1'b0;

    if (dmem_busy) begin
      pc_en_c     = 1'b0;
      if_id_en_c  = 1'b0;
      pipe_hold_c = 1'b1;
    end else if (branch_taken) begin
      if_id_flush_c    = 1'b1;
      id_ex_ctrl_sel_c = 1'b0;
      state_d          = ST_RUN;
      bcnt_d           = '0;
    end else if ((state_q == ST_LDSTALL) || hz_c) begin
      pc_en_c          = 1'b0;
      if_id_en_c       = 1'b0;
      id_ex_ctrl_sel_c = 1'b0;
      stall_active_c   = 1'b1;
      cnt_inc_c        = 1'b1;
      if (state_q == ST_LDSTALL) begin
        if (bcnt_q == BCNT_W'(1)) begin
          state_d = ST_RUN;
          bcnt_d  = '0;
        end else begin
          bcnt_d = BCNT_W'(bcnt_q - BCNT_W'(1));
        end
      end else if (LOAD_BUBBLES > 1) begin
        state_d = ST_LDSTALL;
        bcnt_d  = BCNT_W'(LOAD_BUBBLES - 1);
      end
    end
  end

  // Saturating bubble counter; clear wins over a coincident increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (cnt_inc_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = CNT_W'(stall_cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      bcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are forced inactive for as long as reset is held
  assign pc_en          = rst_n & pc_en_c;
  assign if_id_en       = rst_n & if_id_en_c;
  assign id_ex_ctrl_sel = rst_n & id_ex_ctrl_sel_c;
  assign if_id_flush    = rst_n & if_id_flush_c;
  assign pipe_hold      = rst_n & pipe_hold_c;
  assign stall_active   = rst_n & stall_active_c;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: three hazard_ctrl_unit variants (1/2/3 bubbles, one with a narrow counter)
// share directed and random stimulus and are compared against a bubble-debt reference model.
module tb_hazard_ctrl_unit;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_ex_mem_rd;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic       if_id_rs1_vld, if_id_rs2_vld;
  logic       branch_taken, dmem_busy, stall_cnt_clr;

  logic [5:0]  ov0, ov1, ov2;
  logic [15:0] c0, c2;
  logic [3:0]  c1;

  int lb   [NI] = '{1, 2, 3};
  int cmax [NI] = '{65535, 15, 65535};
  int owed [NI];
  int cnt  [NI];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_BUBBLES(1), .X0_EXEMPT(1), .CNT_W(16)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_rd(id_ex_mem_rd), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rs1_vld(if_id_rs1_vld),
    .if_id_rs2_vld(if_id_rs2_vld), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .stall_cnt_clr(stall_cnt_clr), .pc_en(ov0[5]), .if_id_en(ov0[4]), .id_ex_ctrl_sel(ov0[3]),
    .if_id_flush(ov0[2]), .pipe_hold(ov0[1]), .stall_active(ov0[0]), .stall_cnt(c0));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_BUBBLES(2), .X0_EXEMPT(1), .CNT_W(4)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_rd(id_ex_mem_rd), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rs1_vld(if_id_rs1_vld),
    .if_id_rs2_vld(if_id_rs2_vld), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .stall_cnt_clr(stall_cnt_clr), .pc_en(ov1[5]), .if_id_en(ov1[4]), .id_ex_ctrl_sel(ov1[3]),
    .if_id_flush(ov1[2]), .pipe_hold(ov1[1]), .stall_active(ov1[0]), .stall_cnt(c1));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_BUBBLES(3), .X0_EXEMPT(1), .CNT_W(16)) u_lb3 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_rd(id_ex_mem_rd), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rs1_vld(if_id_rs1_vld),
    .if_id_rs2_vld(if_id_rs2_vld), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .stall_cnt_clr(stall_cnt_clr), .pc_en(ov2[5]), .if_id_en(ov2[4]), .id_ex_ctrl_sel(ov2[3]),
    .if_id_flush(ov2[2]), .pipe_hold(ov2[1]), .stall_active(ov2[0]), .stall_cnt(c2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit load_use();
    if (!id_ex_mem_rd || id_ex_rd == 5'd0) return 1'b0;
    return (if_id_rs1_vld && if_id_rs1 == id_ex_rd) || (if_id_rs2_vld && if_id_rs2 == id_ex_rd);
  endfunction

  // Expected {pc_en, if_id_en, id_ex_ctrl_sel, if_id_flush, pipe_hold, stall_active}
  function automatic logic [5:0] exp_ctl(input int i);
    if (!rst_n)                        return 6'b000000;
    if (dmem_busy)                     return 6'b001010;
    if (branch_taken)                  return 6'b110100;
    if (owed[i] > 0 || load_use())     return 6'b000001;
    return 6'b111000;
  endfunction

  function automatic logic [5:0] dut_ctl(input int i);
    case (i)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [15:0] dut_cnt(input int i);
    case (i)
      0:       return c0;
      1:       return {12'd0, c1};
      default: return c2;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      owed[i] = 0;
      cnt[i]  = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s_ctl_lb%0d", tag, lb[i]), 32'(dut_ctl(i)), 32'(exp_ctl(i)));
      check_eq($sformatf("%s_cnt_lb%0d", tag, lb[i]), 32'(dut_cnt(i)), 32'(cnt[i]));
    end
  endtask

  // Entered at a falling edge with inputs already applied; leaves at the next falling edge
  task automatic cycle(input string tag);
    bit hz;
    #1;
    compare_all(tag);
    hz = load_use();
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        bit bump;
        bump = 1'b0;
        if (!dmem_busy) begin
          if (branch_taken) begin
            owed[i] = 0;
          end else if (owed[i] > 0) begin
            owed[i]--;
            bump = 1'b1;
          end else if (hz) begin
            owed[i] = lb[i] - 1;
            bump = 1'b1;
          end
        end
        if (stall_cnt_clr)                cnt[i] = 0;
        else if (bump && cnt[i] < cmax[i]) cnt[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(input bit ld, input int rd, input int r1, input bit v1,
                        input int r2, input bit v2, input bit br, input bit busy, input bit clr);
    id_ex_mem_rd  = ld;
    id_ex_rd      = 5'(rd);
    if_id_rs1     = 5'(r1);
    if_id_rs1_vld = v1;
    if_id_rs2     = 5'(r2);
    if_id_rs2_vld = v2;
    branch_taken  = br;
    dmem_busy     = busy;
    stall_cnt_clr = clr;
  endtask

  task automatic idle(input int n, input string tag);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_reset");

    // Basic load-use on rs1
    set_in(1, 5, 5, 1, 0, 0, 0, 0, 0);
    cycle("lu_rs1");
    idle(4, "lu_rs1_drain");

    // x0 destination and invalid rs2 never stall
    set_in(1, 0, 0, 1, 0, 1, 0, 0, 0);
    cycle("x0_exempt");
    set_in(1, 7, 0, 0, 7, 0, 0, 0, 0);
    cycle("rs2_not_vld");
    set_in(1, 7, 0, 0, 7, 1, 0, 0, 0);
    cycle("lu_rs2");
    idle(4, "lu_rs2_drain");

    // Branch on the second bubble drops the rest
    set_in(1, 9, 9, 1, 0, 0, 0, 0, 0);
    cycle("br_hz");
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("br_flush");
    idle(3, "br_after");

    // Memory freeze in the middle of a multi-bubble stall
    set_in(1, 3, 1, 1, 3, 1, 0, 0, 0);
    cycle("busy_hz");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) cycle("busy_freeze");
    idle(4, "busy_resume");

    // Clear coinciding with an increment
    set_in(1, 4, 4, 1, 0, 0, 0, 0, 1);
    cycle("clr_inc");
    idle(3, "clr_after");

    // Asynchronous reset in the middle of a bubble sequence
    set_in(1, 6, 6, 1, 0, 0, 0, 0, 0);
    cycle("rst_hz");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("rst_mid");
    @(negedge clk);
    compare_all("rst_hold");
    rst_n = 1'b1;
    idle(3, "rst_release");

    // Randomized traffic with small register indices to force collisions
    for (int n = 0; n < 3000; n++) begin
      set_in(1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 63) == 0));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
